// File: rtl/key_event_decoder.sv
// Gesture classifier behind the key debouncer: turns settled press/release edges
// into single-cycle short-press, long-press and double-click pulses.
module key_event_decoder #(
    parameter int LONG_CYC = 50_000_000,
    parameter int DBL_CYC  = 12_500_000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    input  logic key_value,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse
);

    // state  | meaning
    // IDLE   | no gesture in progress
    // PRESS1 | first press held, timing towards a long press
    // WAIT2  | first press released, waiting for a second press
    // PRESS2 | second press of a double click held
    // HOLD   | long press reported, waiting for release
    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press_edge;
    logic             release_edge;
    logic             short_nxt;
    logic             long_nxt;
    logic             double_nxt;

    // Strobes that repeat the current level are debouncer noise and do nothing.
    assign press_edge   = flag & ~key_value &  stable;
    assign release_edge = flag &  key_value & ~stable;

    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_edge) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (release_edge) begin
                    state_nxt = WAIT2;
                end else if (cnt == LONG_TC) begin
                    state_nxt = HOLD;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_edge) begin
                    state_nxt = PRESS2;
                end else if (cnt == DBL_TC) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (release_edge) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (release_edge) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            stable       <= 1'b1;
            cnt          <= '0;
            pressed      <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            double_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            short_pulse  <= short_nxt;
            long_pulse   <= long_nxt;
            double_pulse <= double_nxt;
            if (press_edge || release_edge) begin
                stable  <= key_value;
                pressed <= ~key_value;
            end
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: expected pulses (kind and cycle) are queued
// as gestures are driven and matched against every pulse the DUT emits.
module tb_key_event_decoder;

    localparam int LONG_CYC = 20;
    localparam int DBL_CYC  = 8;
    localparam int CNT_W    = 5;

    localparam logic [2:0] K_SHORT = 3'b001;
    localparam logic [2:0] K_LONG  = 3'b010;
    localparam logic [2:0] K_DBL   = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flag = 1'b0;
    logic key_value = 1'b1;
    logic pressed;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] kind;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [2:0] k_obs;

    key_event_decoder #(
        .LONG_CYC(LONG_CYC),
        .DBL_CYC (DBL_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flag        (flag),
        .key_value   (key_value),
        .pressed     (pressed),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .double_pulse(double_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One input cycle; the cycle index of these inputs is cyc on return.
    task automatic cyc_in(input logic f, input logic kv);
        @(negedge clk);
        flag      = f;
        key_value = f ? kv : 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_in(1'b0, 1'b0);
    endtask

    task automatic expect_pulse(input logic [2:0] kind, input int at);
        sb.push_back('{kind, at});
    endtask

    task automatic drain(input string tag);
        idle(DBL_CYC + 4);
        check(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (short_pulse || long_pulse || double_pulse)) begin
            k_obs = {double_pulse, long_pulse, short_pulse};
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, k_obs}, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {29'd0, k_obs}, {29'd0, e.kind});
                check("pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int q;

        #1;
        check("rst_pressed", pressed, 0);
        check("rst_short", short_pulse, 0);
        check("rst_long", long_pulse, 0);
        check("rst_double", double_pulse, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(40);

        // short press: release 5 cycles after press, short after the double-click window
        cyc_in(1'b1, 1'b0);
        p = cyc;
        for (int i = 1; i < 5; i++) begin
            cyc_in(1'b0, 1'b0);
            check("s1_pressed_held", pressed, 1);
        end
        expect_pulse(K_SHORT, p + 5 + DBL_CYC + 1);
        cyc_in(1'b1, 1'b1);
        check("s1_pressed_at_release", pressed, 1);
        cyc_in(1'b0, 1'b0);
        check("s1_pressed_after", pressed, 0);
        idle(DBL_CYC + 2);
        drain("s1_queue_empty");

        // long press, released much later with no further pulse
        cyc_in(1'b1, 1'b0);
        p = cyc;
        expect_pulse(K_LONG, p + LONG_CYC + 1);
        idle(39);
        check("s2_pressed_held", pressed, 1);
        cyc_in(1'b1, 1'b1);
        idle(DBL_CYC + 6);
        check("s2_pressed_after", pressed, 0);
        drain("s2_queue_empty");

        // double click, second press held beyond the long threshold
        cyc_in(1'b1, 1'b0);
        p = cyc;
        idle(3);
        cyc_in(1'b1, 1'b1);
        idle(4);
        cyc_in(1'b1, 1'b0);
        idle(20);
        expect_pulse(K_DBL, p + 31);
        cyc_in(1'b1, 1'b1);
        idle(DBL_CYC + 6);
        drain("s3_queue_empty");

        // redundant strobes in IDLE and PRESS1 leave state and counter alone
        repeat (3) begin
            cyc_in(1'b1, 1'b1);
            idle(2);
        end
        check("s4_idle_pressed", pressed, 0);
        cyc_in(1'b1, 1'b0);
        p = cyc;
        expect_pulse(K_LONG, p + LONG_CYC + 1);
        idle(4);
        repeat (3) cyc_in(1'b1, 1'b0);
        idle(20);
        check("s4_pressed_held", pressed, 1);
        cyc_in(1'b1, 1'b1);
        idle(4);
        drain("s4_queue_empty");

        // release on the same cycle as the long terminal count
        cyc_in(1'b1, 1'b0);
        p = cyc;
        idle(LONG_CYC - 1);
        expect_pulse(K_SHORT, p + LONG_CYC + DBL_CYC + 1);
        cyc_in(1'b1, 1'b1);
        idle(DBL_CYC + 6);
        drain("r1_queue_empty");

        // second press on the same cycle as the double-click terminal count
        cyc_in(1'b1, 1'b0);
        p = cyc;
        idle(2);
        cyc_in(1'b1, 1'b1);
        idle(DBL_CYC - 1);
        cyc_in(1'b1, 1'b0);
        idle(3);
        expect_pulse(K_DBL, p + 3 + DBL_CYC + 5);
        cyc_in(1'b1, 1'b1);
        idle(4);
        drain("r2_queue_empty");

        // reset mid-PRESS1 discards the gesture; held key counts as a fresh press
        cyc_in(1'b1, 1'b0);
        idle(6);
        check("rs_pressed_before", pressed, 1);
        @(negedge clk);
        rst  = 1'b1;
        flag = 1'b0;
        #1;
        check("rs_pressed", pressed, 0);
        check("rs_short", short_pulse, 0);
        check("rs_long", long_pulse, 0);
        check("rs_double", double_pulse, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(LONG_CYC + 4);
        check("rs_pressed_after_rst", pressed, 0);
        cyc_in(1'b1, 1'b0);
        q = cyc;
        cyc_in(1'b0, 1'b0);
        check("rs_new_press", pressed, 1);
        idle(1);
        expect_pulse(K_SHORT, q + 3 + DBL_CYC + 1);
        cyc_in(1'b1, 1'b1);
        idle(LONG_CYC + 6);
        drain("rs_queue_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
